// File: rtl/led_spawner_if.sv
`default_nettype none
// ============================================================================
// Module      : led_spawner_if
// Description : Game-control bundle between the LED spawner and the
//               LED/switch scoring block.
// Revision    : 1.0 - initial release
// ============================================================================
interface led_spawner_if #(
  parameter int NUM_LEDS = 18
);
  logic                start;
  logic [NUM_LEDS-1:0] leds_active;
  logic [4:0]          led_index;
  logic                led_request;
  logic                game_active;
  logic                game_over;
  logic [7:0]          time_left;

  modport master (
    input  start, leds_active,
    output led_index, led_request, game_active, game_over, time_left
  );

  modport slave (
    output start, leds_active,
    input  led_index, led_request, game_active, game_over, time_left
  );
endinterface
`default_nettype wire

// File: rtl/led_spawner.sv
`default_nettype none
// ============================================================================
// Module      : led_spawner
// Description : Timed game sequencer; spawns LEDs at pseudo-random free
//               indices and counts down the game clock.
// Revision    : 1.0 - initial release
// ============================================================================
module led_spawner #(
  parameter int          SEC_CYCLES   = 20_000_000,
  parameter int          SPAWN_CYCLES = 20_000_000,
  parameter int          GAME_SECS    = 30,
  parameter int          NUM_LEDS     = 18,
  parameter int          MAX_TRIES    = 8,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  wire logic clk,
  input  wire logic rst,
  led_spawner_if.master bus
);

  localparam int SEC_W   = (SEC_CYCLES > 1)   ? $clog2(SEC_CYCLES)   : 1;
  localparam int SPAWN_W = (SPAWN_CYCLES > 1) ? $clog2(SPAWN_CYCLES) : 1;
  localparam int TRY_W   = $clog2(MAX_TRIES + 1);

  localparam logic [SEC_W-1:0]   c_sec_last   = SEC_W'(SEC_CYCLES - 1);
  localparam logic [SPAWN_W-1:0] c_spawn_last = SPAWN_W'(SPAWN_CYCLES - 1);
  localparam logic [TRY_W-1:0]   c_max_tries  = TRY_W'(MAX_TRIES);
  localparam logic [7:0]         c_game_secs  = 8'(GAME_SECS);
  localparam logic [15:0]        c_lfsr_init  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0]        c_lfsr_taps  = 16'hB400;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PICK = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               r_state,     w_state;
  logic [15:0]          r_lfsr,      w_lfsr;
  logic [SEC_W-1:0]     r_sec_cnt,   w_sec_cnt;
  logic [SPAWN_W-1:0]   r_spawn_cnt, w_spawn_cnt;
  logic [TRY_W-1:0]     r_tries,     w_tries;
  logic [7:0]           r_time_left, w_time_left;
  logic [4:0]           r_led_index, w_led_index;
  logic                 r_led_request, w_led_request;

  logic [4:0]           w_cand;
  logic [31:0]          w_occ;
  logic                 w_cand_ok;
  logic                 w_sec_wrap;
  logic                 w_spawn_wrap;
  logic [TRY_W-1:0]     w_tries_inc;

  assign w_cand       = r_lfsr[4:0];
  assign w_occ        = 32'(bus.leds_active);
  assign w_cand_ok    = ({27'd0, w_cand} < 32'(NUM_LEDS)) && !w_occ[w_cand];
  assign w_sec_wrap   = (r_sec_cnt == '0);
  assign w_spawn_wrap = (r_spawn_cnt == '0);
  assign w_tries_inc  = r_tries + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_lfsr        <= c_lfsr_init;
      r_sec_cnt     <= '0;
      r_spawn_cnt   <= '0;
      r_tries       <= '0;
      r_time_left   <= '0;
      r_led_index   <= '0;
      r_led_request <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_lfsr        <= w_lfsr;
      r_sec_cnt     <= w_sec_cnt;
      r_spawn_cnt   <= w_spawn_cnt;
      r_tries       <= w_tries;
      r_time_left   <= w_time_left;
      r_led_index   <= w_led_index;
      r_led_request <= w_led_request;
    end
  end

  always_comb begin
    w_state       = r_state;
    w_lfsr        = (r_lfsr >> 1) ^ (r_lfsr[0] ? c_lfsr_taps : 16'h0000);
    w_sec_cnt     = r_sec_cnt;
    w_spawn_cnt   = r_spawn_cnt;
    w_tries       = r_tries;
    w_time_left   = r_time_left;
    w_led_index   = r_led_index;
    w_led_request = 1'b0;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_state     = S_RUN;
          w_time_left = c_game_secs;
          w_sec_cnt   = c_sec_last;
          w_spawn_cnt = c_spawn_last;
          w_tries     = '0;
        end
      end

      S_RUN, S_PICK: begin
        if (w_sec_wrap) begin
          w_sec_cnt   = c_sec_last;
          w_time_left = r_time_left - 8'd1;
        end else begin
          w_sec_cnt   = r_sec_cnt - 1'b1;
        end

        // The spawn timer free-runs through PICK so the spawn period stays fixed.
        w_spawn_cnt = w_spawn_wrap ? c_spawn_last : r_spawn_cnt - 1'b1;

        if (r_state == S_RUN) begin
          if (w_spawn_wrap) begin
            w_state = S_PICK;
            w_tries = '0;
          end
        end else if (w_cand_ok) begin
          w_led_index   = w_cand;
          w_led_request = 1'b1;
          w_state       = S_RUN;
        end else begin
          w_tries = w_tries_inc;
          if (w_tries_inc == c_max_tries) begin
            w_state = S_RUN;
          end
        end

        // Game end overrides any spawn decided on the same edge.
        if (w_sec_wrap && (r_time_left == 8'd1)) begin
          w_state       = S_DONE;
          w_time_left   = 8'd0;
          w_led_index   = r_led_index;
          w_led_request = 1'b0;
        end
      end

      default: w_state = S_IDLE;
    endcase
  end

  assign bus.led_index   = r_led_index;
  assign bus.led_request = r_led_request;
  assign bus.game_active = (r_state == S_RUN) || (r_state == S_PICK);
  assign bus.game_over   = (r_state == S_DONE);
  assign bus.time_left   = r_time_left;

endmodule
`default_nettype wire

// File: tb/tb_led_spawner.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_spawner
// Description : Three spawners (3, 10 and 20 second games) checked each cycle
//               against a game-time reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_led_spawner;

  localparam int          SEC   = 10;
  localparam int          SPAWN = 20;
  localparam int          NL    = 18;
  localparam int          MAXT  = 8;
  localparam logic [15:0] SEED  = 16'h0001;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [NL-1:0] leds [3];
  bit            chk_en = 1'b0;
  int            vectors = 0;
  int            miscompares = 0;

  always #5 clk = ~clk;

  initial begin
    @(posedge clk);
    chk_en = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int GS = (g == 0) ? 3 : ((g == 1) ? 10 : 20);

    led_spawner_if #(.NUM_LEDS(NL)) bus ();
    assign bus.start       = start;
    assign bus.leds_active = leds[g];

    led_spawner #(
      .SEC_CYCLES  (SEC),
      .SPAWN_CYCLES(SPAWN),
      .GAME_SECS   (GS),
      .NUM_LEDS    (NL),
      .MAX_TRIES   (MAXT),
      .LFSR_SEED   (SEED)
    ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );

    // Model tracks the game by elapsed cycle t (the cycle now visible).
    logic [15:0] m_lfsr;
    int          t;
    bit          ingame, over, req, pick;
    int          tries;
    logic [4:0]  idx;

    always @(posedge clk) begin : p_model
      logic [4:0]  cand;
      logic [31:0] occ;
      bit          ok, req_n;
      logic [4:0]  idx_n;
      cand = m_lfsr[4:0];
      occ  = 32'(leds[g]);
      ok   = (int'(cand) < NL) && !occ[cand];
      if (rst) begin
        m_lfsr = (SEED == 16'h0) ? 16'h0001 : SEED;
        t = 0; ingame = 0; over = 0; req = 0; pick = 0; tries = 0; idx = '0;
      end else begin
        req_n = 0;
        idx_n = idx;
        if (!ingame) begin
          if (start) begin
            ingame = 1; over = 0; t = 1; pick = 0;
          end
        end else begin
          if (pick) begin
            if (ok) begin
              req_n = 1; idx_n = cand; pick = 0;
            end else begin
              tries++;
              if (tries == MAXT) pick = 0;
            end
          end else if (t % SPAWN == 0) begin
            pick = 1; tries = 0;
          end
          if (t == GS * SEC) begin
            ingame = 0; over = 1; pick = 0; req_n = 0; idx_n = idx;
          end
          t++;
        end
        req    = req_n;
        idx    = idx_n;
        m_lfsr = lfsr_next(m_lfsr);
      end
    end

    always @(negedge clk) begin : p_compare
      int exp_time;
      if (chk_en) begin
        exp_time = ingame ? (GS - (t - 1) / SEC) : 0;
        check($sformatf("g%0d.time_left", g), 32'(bus.time_left), 32'(exp_time));
        check($sformatf("g%0d.game_active", g), 32'(bus.game_active), 32'(ingame));
        check($sformatf("g%0d.game_over", g), 32'(bus.game_over), 32'(over));
        check($sformatf("g%0d.led_request", g), 32'(bus.led_request), 32'(req));
        check($sformatf("g%0d.led_index", g), 32'(bus.led_index), 32'(idx));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_idle0(input string tag);
    check({tag, ".active"}, 32'(g_inst[0].bus.game_active), 32'd0);
    check({tag, ".over"},   32'(g_inst[0].bus.game_over),   32'd0);
    check({tag, ".time"},   32'(g_inst[0].bus.time_left),   32'd0);
    check({tag, ".req"},    32'(g_inst[0].bus.led_request), 32'd0);
    check({tag, ".index"},  32'(g_inst[0].bus.led_index),   32'd0);
  endtask

  // Runs cycles 1..ncyc of a 3 s game on instance 0 with literal timing checks.
  task automatic run_game0(input string tag, input int ncyc, input bit hold_start);
    int pulses = 0;
    int pc = -1;
    for (int c = 1; c <= ncyc; c++) begin
      if (hold_start) start = (c >= 5 && c < 15);
      if (g_inst[0].bus.led_request) begin pulses++; pc = c; end
      if (c == 1)  check({tag, ".time_c1"},  32'(g_inst[0].bus.time_left), 32'd3);
      if (c == 1)  check({tag, ".active_c1"}, 32'(g_inst[0].bus.game_active), 32'd1);
      if (c == 11) check({tag, ".time_c11"}, 32'(g_inst[0].bus.time_left), 32'd2);
      if (c == 21) check({tag, ".time_c21"}, 32'(g_inst[0].bus.time_left), 32'd1);
      if (c == 30) check({tag, ".over_c30"}, 32'(g_inst[0].bus.game_over), 32'd0);
      if (c == 31) begin
        check({tag, ".time_c31"},   32'(g_inst[0].bus.time_left),   32'd0);
        check({tag, ".over_c31"},   32'(g_inst[0].bus.game_over),   32'd1);
        check({tag, ".active_c31"}, 32'(g_inst[0].bus.game_active), 32'd0);
      end
      tick();
    end
    start = 1'b0;
    check({tag, ".pulse_count"}, 32'(pulses), 32'd1);
    check({tag, ".pulse_window"}, 32'(pc >= 22 && pc <= 29), 32'd1);
  endtask

  initial begin
    int p1, p2, m2, bad2, idle_req;
    leds[0] = '0;
    leds[1] = '1;
    leds[2] = ~(NL'(1) << 5);

    repeat (3) tick();
    check_idle0("reset");
    rst = 1'b0;

    idle_req = 0;
    for (int c = 0; c < 50; c++) begin
      for (int k = 0; k < 3; k++) ;
      if (g_inst[0].bus.led_request || g_inst[1].bus.led_request || g_inst[2].bus.led_request)
        idle_req++;
      tick();
    end
    check("idle.no_request", 32'(idle_req), 32'd0);
    check_idle0("idle");

    // Basic game on inst 0; full board on inst 1; single free LED on inst 2.
    start = 1'b1;
    tick();
    start = 1'b0;
    p1 = 0; p2 = 0; m2 = 0; bad2 = 0;
    begin
      int pulses0 = 0;
      int pc0 = -1;
      for (int c = 1; c <= 205; c++) begin
        if (g_inst[0].bus.led_request) begin pulses0++; pc0 = c; end
        if (g_inst[1].bus.led_request) p1++;
        if (g_inst[2].bus.led_request) begin
          p2++;
          if (g_inst[2].bus.led_index != 5'd5) bad2++;
        end
        if (g_inst[2].req) m2++;
        if (c == 1)   check("basic.active_c1", 32'(g_inst[0].bus.game_active), 32'd1);
        if (c == 1)   check("basic.time_c1",   32'(g_inst[0].bus.time_left),   32'd3);
        if (c == 11)  check("basic.time_c11",  32'(g_inst[0].bus.time_left),   32'd2);
        if (c == 21)  check("basic.time_c21",  32'(g_inst[0].bus.time_left),   32'd1);
        if (c == 31)  check("basic.time_c31",  32'(g_inst[0].bus.time_left),   32'd0);
        if (c == 31)  check("basic.over_c31",  32'(g_inst[0].bus.game_over),   32'd1);
        if (c == 100) check("full.time_c100",  32'(g_inst[1].bus.time_left),   32'd1);
        if (c == 101) check("full.time_c101",  32'(g_inst[1].bus.time_left),   32'd0);
        if (c == 101) check("full.over_c101",  32'(g_inst[1].bus.game_over),   32'd1);
        if (c == 201) check("single.over_c201", 32'(g_inst[2].bus.game_over),  32'd1);
        tick();
      end
      check("basic.pulse_count", 32'(pulses0), 32'd1);
      check("basic.pulse_window", 32'(pc0 >= 22 && pc0 <= 29), 32'd1);
    end
    check("full.no_request", 32'(p1), 32'd0);
    check("single.index_5", 32'(bad2), 32'd0);
    check("single.pulse_count", 32'(p2), 32'(m2));

    // Restart from DONE, with start held high partway through RUN.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart.over_cleared", 32'(g_inst[0].bus.game_over), 32'd0);
    run_game0("restart", 40, 1'b1);

    // Reset mid-game, then restart.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 15; c++) tick();
    rst = 1'b1;
    tick();
    check_idle0("midreset_c16");
    rst = 1'b0;
    for (int c = 16; c < 20; c++) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("midreset.time_c21",   32'(g_inst[0].bus.time_left),   32'd3);
    check("midreset.active_c21", 32'(g_inst[0].bus.game_active), 32'd1);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      leds[0] = NL'($urandom & $urandom);
      if ($urandom_range(0, 3) == 0) leds[2] = NL'($urandom | $urandom | $urandom);
      start = ($urandom_range(0, 39) == 0);
      rst   = ($urandom_range(0, 599) == 0);
      tick();
    end
    start = 1'b0;
    rst   = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
